// File: rtl/instr_decode_pipe_pkg.sv
// Shared decode constants: result-source, ALU opcode, immediate-format and
// memory-width encodings, plus the packed control bundle carried to execute.
package instr_decode_pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_SLL   = 6'd2;
    localparam logic [5:0] ALU_SLT   = 6'd3;
    localparam logic [5:0] ALU_SLTU  = 6'd4;
    localparam logic [5:0] ALU_XOR   = 6'd5;
    localparam logic [5:0] ALU_SRL   = 6'd6;
    localparam logic [5:0] ALU_SRA   = 6'd7;
    localparam logic [5:0] ALU_OR    = 6'd8;
    localparam logic [5:0] ALU_AND   = 6'd9;
    localparam logic [5:0] ALU_PASSB = 6'd10;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    typedef struct packed {
        logic       rd_we;
        logic       branch;
        logic       jump;
        logic       mem_we;
        logic       alu_src;
        logic [1:0] res_src;
        logic [2:0] mem_width;
        logic [5:0] alu_op;
    } ctrl_t;

    // Arithmetic/logic op from funct3; alt selects SUB/SRA.
    function automatic logic [5:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_control_unit.sv
// Main decoder: opcode/funct fields to the execute control bundle and the
// immediate format select.
module decode_control_unit
    import instr_decode_pipe_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl,
    output imm_sel_t   imm_sel
);

    logic [2:0] legal_width;

    // Unsupported load/store widths fall back to word access.
    always_comb begin
        case (funct3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal_width = funct3;
            default:                             legal_width = MEM_W;
        endcase
    end

    // Per-opcode control generation; unknown opcodes decode as a no-op.
    always_comb begin
        ctrl    = '0;
        imm_sel = IMM_I;
        case (opcode)
            OP_LUI: begin
                ctrl.rd_we   = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_PASSB;
                imm_sel      = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.rd_we   = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                imm_sel      = IMM_U;
            end
            OP_JAL: begin
                ctrl.rd_we   = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.res_src = RES_PC4;
                imm_sel      = IMM_J;
            end
            OP_JALR: begin
                ctrl.rd_we   = 1'b1;
                ctrl.jump    = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.res_src = RES_PC4;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                imm_sel     = IMM_B;
                case (funct3[2:1])
                    2'b10:   ctrl.alu_op = ALU_SLT;
                    2'b11:   ctrl.alu_op = ALU_SLTU;
                    default: ctrl.alu_op = ALU_SUB;
                endcase
            end
            OP_LOAD: begin
                ctrl.rd_we     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.res_src   = RES_MEM;
                ctrl.mem_width = legal_width;
            end
            OP_STORE: begin
                ctrl.mem_we    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_width = legal_width;
                imm_sel        = IMM_S;
            end
            OP_IMM: begin
                ctrl.rd_we   = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7_5);
            end
            OP_REG: begin
                ctrl.rd_we  = 1'b1;
                ctrl.alu_op = alu_from_funct3(funct3, funct7_5);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// Load-use hazard compare between the load held in ID/EX and the source
// registers of the instruction being decoded. Active only with
// LOAD_USE_STALL_EN defined; otherwise the hazard output is tied low.
module decode_hazard_unit
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            ex_valid,
    input  logic [1:0]      ex_res_src,
    input  logic            ex_rd_we,
    input  logic [RA_W-1:0] ex_rd_addr,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    output logic            hazard
);

`ifdef LOAD_USE_STALL_EN
    // Conservative: compares both sources regardless of instruction format.
    always_comb begin
        hazard = ex_valid && (ex_res_src == RES_MEM) && ex_rd_we &&
                 (ex_rd_addr != '0) &&
                 ((ex_rd_addr == id_rs1) || (ex_rd_addr == id_rs2));
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{ex_valid, ex_res_src, ex_rd_we, ex_rd_addr, id_rs1, id_rs2};
    assign hazard        = 1'b0;
`endif

endmodule

// File: rtl/imm_extender.sv
// Immediate extraction and sign extension to XLEN for the I/S/B/U/J formats.
module imm_extender
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr_hi,
    input  imm_sel_t        imm_sel,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Reassemble the format-specific immediate bits into a 32-bit value.
    always_comb begin
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr_hi[31]}}, instr_hi[31:20]};
            IMM_S:   imm32 = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            IMM_B:   imm32 = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                              instr_hi[30:25], instr_hi[11:8], 1'b0};
            IMM_U:   imm32 = {instr_hi[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                              instr_hi[20], instr_hi[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/regfile.sv
// NREGS x XLEN register file, two read ports, one write port, x0 hardwired
// to zero, with same-cycle write-to-read bypass. Contents are not reset.
module regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_live;

    assign wr_live = we && (waddr != '0);

    // Writes commit on the rising edge; x0 is never written.
    always_ff @(posedge clk) begin
        if (wr_live) mem[waddr] <= wdata;
    end

    // Reads: x0 is zero, a matching write this cycle is forwarded.
    always_comb begin
        if (rs1_addr == '0)                       rs1_data = '0;
        else if (wr_live && (waddr == rs1_addr))  rs1_data = wdata;
        else                                      rs1_data = mem[rs1_addr];
        if (rs2_addr == '0)                       rs2_data = '0;
        else if (wr_live && (waddr == rs2_addr))  rs2_data = wdata;
        else                                      rs2_data = mem[rs2_addr];
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Decode stage with an elastic ID/EX register: valid/ready backpressure,
// flush, writeback bypass, and optional load-use bubble insertion
// (enabled by defining LOAD_USE_STALL_EN).
module instr_decode_pipe
    import instr_decode_pipe_pkg::*;
#(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NREGS    = 32,
    parameter  int unsigned ALU_OP_W = 6,
    localparam int unsigned RA_W     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     next_pc_in,
    input  logic                flush,
    input  logic                reg_write_enable,
    input  logic [RA_W-1:0]     reg_write_addr,
    input  logic [XLEN-1:0]     reg_write_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     next_pc_out,
    output logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [RA_W-1:0]     rs1_addr,
    output logic [RA_W-1:0]     rs2_addr,
    output logic [RA_W-1:0]     rd_write_addr,
    output logic                rd_write_enable,
    output logic                branch,
    output logic                jump,
    output logic                mem_write_enable,
    output logic                alu_input_conf,
    output logic [1:0]          res_src,
    output logic [2:0]          mem_width_out,
    output logic [ALU_OP_W-1:0] alu_op
);

    ctrl_t           dec_ctrl;
    ctrl_t           ctrl_q;
    imm_sel_t        imm_sel;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RA_W-1:0] rs1_idx;
    logic [RA_W-1:0] rs2_idx;
    logic [RA_W-1:0] rd_idx;
    logic            hazard;
    logic            advance;

    assign rs1_idx = instr[15 +: RA_W];
    assign rs2_idx = instr[20 +: RA_W];
    assign rd_idx  = instr[7 +: RA_W];

    decode_control_unit u_ctrl (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .ctrl     (dec_ctrl),
        .imm_sel  (imm_sel)
    );

    imm_extender #(.XLEN(XLEN)) u_imm (
        .instr_hi (instr[31:7]),
        .imm_sel  (imm_sel),
        .imm      (dec_imm)
    );

    regfile #(.XLEN(XLEN), .NREGS(NREGS), .RA_W(RA_W)) u_rf (
        .clk      (clk),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .we       (reg_write_enable),
        .waddr    (reg_write_addr),
        .wdata    (reg_write_data),
        .rs1_data (rd1),
        .rs2_data (rd2)
    );

    decode_hazard_unit #(.RA_W(RA_W)) u_hz (
        .ex_valid   (out_valid),
        .ex_res_src (ctrl_q.res_src),
        .ex_rd_we   (ctrl_q.rd_we),
        .ex_rd_addr (rd_write_addr),
        .id_rs1     (rs1_idx),
        .id_rs2     (rs2_idx),
        .hazard     (hazard)
    );

    assign advance  = !out_valid || out_ready;
    assign in_ready = flush || (advance && !hazard);

    // ID/EX register: reset > flush > advance; bubbles and flushed slots
    // clear control but keep the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            ctrl_q        <= '0;
            pc_out        <= '0;
            next_pc_out   <= '0;
            imm           <= '0;
            rs1_data      <= '0;
            rs2_data      <= '0;
            rs1_addr      <= '0;
            rs2_addr      <= '0;
            rd_write_addr <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (advance) begin
            if (hazard) begin
                out_valid <= 1'b0;
                ctrl_q    <= '0;
            end else begin
                out_valid     <= in_valid;
                ctrl_q        <= in_valid ? dec_ctrl : '0;
                pc_out        <= pc_in;
                next_pc_out   <= next_pc_in;
                imm           <= dec_imm;
                rs1_data      <= rd1;
                rs2_data      <= rd2;
                rs1_addr      <= rs1_idx;
                rs2_addr      <= rs2_idx;
                rd_write_addr <= rd_idx;
            end
        end
    end

    assign rd_write_enable  = ctrl_q.rd_we;
    assign branch           = ctrl_q.branch;
    assign jump             = ctrl_q.jump;
    assign mem_write_enable = ctrl_q.mem_we;
    assign alu_input_conf   = ctrl_q.alu_src;
    assign res_src          = ctrl_q.res_src;
    assign mem_width_out    = ctrl_q.mem_width;
    assign alu_op           = ALU_OP_W'(ctrl_q.alu_op);

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Parametrised decode stage with an elastic ID/EX pipeline register. It decodes the instruction, reads the register file, extends the immediate, and registers the full control/data bundle for execute. Unlike a free-running stage, it supports valid/ready backpressure, flush, and writeback-to-decode bypass. It optionally detects load-use hazards and inserts a one-cycle bubble. It sits between fetch and execute and replaces the fixed 32-bit decode stage.

## Interface
- XLEN, 32: data/PC width.
- NREGS, 32: architectural register count (32 or 16); RA_W = $clog2(NREGS).
- ALU_OP_W, 6: ALU opcode width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  instruction word.
- pc_in, next_pc_in  in  XLEN  instruction PC and sequential next PC.
- flush  in  1  kill the held and the incoming instruction (branch redirect).
- reg_write_enable, reg_write_addr, reg_write_data  in  1/RA_W/XLEN  writeback port.
- out_valid  out  1  the ID/EX bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- pc_out, next_pc_out, imm, rs1_data, rs2_data  out  XLEN  registered data.
- rs1_addr, rs2_addr, rd_write_addr  out  RA_W  registered register indices.
- rd_write_enable, branch, jump, mem_write_enable, alu_input_conf  out  1  registered control.
- res_src  out  2; mem_width_out  out  3; alu_op  out  ALU_OP_W.

## Operation
- Decode, regfile read, and immediate extension are combinational from `instr`. The bundle is captured on an accepted transfer.
- Register indices are instr[19:15], instr[24:20], and instr[11:7], truncated to RA_W.
- x0 always reads 0, and writes to x0 are ignored.
- Bypass: if reg_write_enable is high, reg_write_addr is nonzero, and it equals rs1 or rs2, the read returns reg_write_data in the same cycle.
- advance = !out_valid || out_ready.
- hazard is computed only with the Configuration macro defined:
  - Conditions: out_valid, res_src == RES_MEM, rd_write_enable, and rd_write_addr != 0.
  - It fires when rd_write_addr matches instr's rs1 or rs2 index.
  - The check is conservative: it is applied whether or not the format actually uses rs1/rs2.
- in_ready = flush || (advance && !hazard).
- Register update priority: rst > flush > advance.
  - flush: out_valid <= 0 and all control outputs <= 0. The incoming instruction is discarded.
  - advance && hazard: bubble. out_valid <= 0, control outputs <= 0, data fields hold.
  - advance && !hazard: out_valid <= in_valid and the bundle is loaded. If in_valid = 0, control outputs are cleared.
  - !advance: everything holds.
- Bubbles and flushed slots always carry rd_write_enable = mem_write_enable = branch = jump = 0. This keeps them safe even if execute ignores valid.

## Timing
- Decode-to-execute latency is 1 cycle, and throughput is 1 instruction/cycle without stalls.
- A load-use hazard costs exactly one bubble cycle; the dependent instruction is accepted in the next cycle.
- A regfile write commits on the rising edge; the bypass covers a read in that same cycle.
- Reset values: every output register, including out_valid, is 0. Regfile contents are not reset.
- in_ready is combinational from out_valid, out_ready, flush, and the hazard compare. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-stall: out_valid goes to 0 on the next edge and the held bundle is lost.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection and bubble insertion are active as described above.
- LOAD_USE_STALL_EN undefined: hazard is tied to 0, in_ready = flush || advance, and downstream forwarding or software is responsible for load-use ordering.

## Structure
- The shared constants package holds RES_MEM/RES_ALU/RES_PC4 encodings, ALU opcode encodings, imm_sel encodings, and mem_width encodings.
- The block reuses the existing decode_control_unit, imm_extender, and a regfile generalised to NREGS/XLEN with bypass.
- One new sub-module, decode_hazard_unit, holds the load-use compare and is compiled empty without the macro.

## Test plan
- Reset, then an `addi x1,x0,5` stream with out_ready = 1: out_valid goes high one cycle after acceptance, imm = 5, rd_write_addr = 1, throughput is 1/cycle.
- out_ready = 0 for 3 cycles with the output full: in_ready = 0, and the bundle holds bit-identical across all 3 cycles.
- Writeback of x5 = 0xDEADBEEF in the same cycle as decoding `add x6,x5,x0`: rs1_data = 0xDEADBEEF.
- `lw x7,0(x2)` followed by `add x8,x7,x1` with the macro defined: exactly one bubble (out_valid = 0, rd_write_enable = 0), then the add is issued. With the macro undefined: no bubble.
- flush asserted while the output is valid and out_ready = 0: the next cycle has out_valid = 0 and all control outputs 0, and in_ready = 1 during the flush.
- NREGS = 16 with a write to x0: x0 still reads 0. An instruction with rd = x17 is captured as rd_write_addr = 1 (truncated).
